fib_port_writer: RTL and testbench

FIB_PORT_WRITER -- requirements
Module: fib_port_writer

---
 rtl/fib_port_writer.sv | 116 +++++++++++
 tb/tb_fib_port_writer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_port_writer.sv
// Streams a fixed Fibonacci test pattern to a memory-mapped result port:
// BEGIN_SYM, F0..F15, F15..F0, END_SYM, with one idle bus cycle between writes.
module fib_port_writer #(
    parameter logic [29:0] TEST_PORT = 30'hFF,
    parameter logic [31:0] BEGIN_SYM = 32'h00000168,
    parameter logic [31:0] END_SYM   = 32'hFFFFFD5D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic        mem_wen,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] cycles
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [5:0] MID_IDX  = 6'd16;
    localparam logic [5:0] LAST_IDX = 6'd33;

    logic [1:0]  state_reg, state_next;
    logic [5:0]  idx_reg, idx_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [15:0] cycles_reg, cycles_next;
    logic [15:0] cycles_inc;
    logic [31:0] value;
    logic [31:0] value_swapped;

    assign cycles_inc = (cycles_reg == 16'hFFFF) ? cycles_reg : cycles_reg + 16'd1;

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cycles_next = cycles_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = WRITE;
                    idx_next    = 6'd0;
                    a_next      = 32'd0;
                    b_next      = 32'd1;
                    cycles_next = 16'd0;
                end
            end
            WRITE: begin
                cycles_next = cycles_inc;
                if (!stall) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        state_next = GAP;
                        idx_next   = idx_reg + 6'd1;
                        // Ascending half walks forward; descending half undoes it.
                        if (idx_reg != 6'd0 && idx_reg < MID_IDX) begin
                            a_next = b_reg;
                            b_next = a_reg + b_reg;
                        end else if (idx_reg > MID_IDX) begin
                            a_next = b_reg - a_reg;
                            b_next = a_reg;
                        end
                    end
                end
            end
            GAP: begin
                cycles_next = cycles_inc;
                state_next  = WRITE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            idx_reg    <= 6'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd1;
            cycles_reg <= 16'd0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            cycles_reg <= cycles_next;
        end
    end

    assign value = (idx_reg == 6'd0)     ? BEGIN_SYM :
                   (idx_reg == LAST_IDX) ? END_SYM   : a_reg;

    // Receiver byte-swaps each word, so present the value byte-reversed.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_swap
            assign value_swapped[8*gi +: 8] = value[8*(3-gi) +: 8];
        end
    endgenerate

    assign mem_wen   = (state_reg == WRITE);
    assign mem_addr  = mem_wen ? TEST_PORT : 30'd0;
    assign mem_wdata = mem_wen ? value_swapped : 32'd0;
    assign busy      = (state_reg == WRITE) || (state_reg == GAP);
    assign done      = (state_reg == DONE);
    assign cycles    = cycles_reg;

endmodule

// File: tb/tb_fib_port_writer.sv
// Self-checking bench for fib_port_writer: random and directed stall patterns
// compared against a Fibonacci sequence model computed in the bench.
module tb_fib_port_writer;

    localparam logic [29:0] TEST_PORT = 30'hFF;
    localparam logic [31:0] BEGIN_SYM = 32'h00000168;
    localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        mem_wen;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [15:0] cycles;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] got[$];
    int          runs[$];
    int          stall_cnt;
    logic [15:0] final_cycles;

    fib_port_writer #(
        .TEST_PORT(TEST_PORT),
        .BEGIN_SYM(BEGIN_SYM),
        .END_SYM(END_SYM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stall(stall),
        .mem_wen(mem_wen),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .cycles(cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fib(input int n);
        logic [31:0] x, y, t;
        x = 32'd0;
        y = 32'd1;
        for (int k = 0; k < n; k++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [31:0] exp_value(input int i);
        if (i == 0)  return BEGIN_SYM;
        if (i <= 16) return fib(i - 1);
        if (i <= 32) return fib(32 - i);
        return END_SYM;
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Runs one stream and records accepted words, hold lengths and stalls.
    task automatic run_stream(input int stall_pct, input int force_idx,
                              input int force_len, input int ign_idx);
        int          stalled_here = 0;
        int          run_len = 0;
        bit          prev_acc = 0;
        bit          ign_pending = 0;
        bit          ign_done = 0;
        bit          finished = 0;
        logic [31:0] prev_data = 32'd0;
        got.delete();
        runs.delete();
        stall_cnt = 0;
        final_cycles = 16'd0;
        @(posedge clk); #1;
        start = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                finished = 1;
                final_cycles = cycles;
            end else begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_in_stream: got %b want 1 (write %0d)", busy, got.size());
                end
                if (prev_acc) begin
                    n_cmp++;
                    if (mem_wen !== 1'b0) begin
                        n_err++;
                        $display("FAIL gap_after_write: wen %b want 0 (write %0d)", mem_wen, got.size());
                    end
                end
                if (mem_wen === 1'b1) begin
                    n_cmp++;
                    if (mem_addr !== TEST_PORT) begin
                        n_err++;
                        $display("FAIL addr: got %h want %h", mem_addr, TEST_PORT);
                    end
                    if (run_len > 0) begin
                        n_cmp++;
                        if (mem_wdata !== prev_data) begin
                            n_err++;
                            $display("FAIL stall_hold: got %h want %h", mem_wdata, prev_data);
                        end
                    end
                    run_len++;
                    prev_data = mem_wdata;
                    if (stall) begin
                        stall_cnt++;
                        if (got.size() == force_idx) stalled_here++;
                    end else begin
                        got.push_back(mem_wdata);
                        runs.push_back(run_len);
                        run_len = 0;
                    end
                end else begin
                    n_cmp++;
                    if (mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin
                        n_err++;
                        $display("FAIL idle_bus: addr %h data %h want 0/0", mem_addr, mem_wdata);
                    end
                    if (ign_idx >= 0 && got.size() == ign_idx && !ign_done) ign_pending = 1;
                end
                prev_acc = (mem_wen === 1'b1) && !stall;
            end
            @(posedge clk); #1;
            start = ign_pending;
            if (ign_pending) begin
                ign_pending = 0;
                ign_done = 1;
            end
            if (stall_pct > 0)
                stall = ($urandom_range(99) < stall_pct);
            else
                stall = (got.size() == force_idx) && (stalled_here < force_len);
        end
        stall = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (!finished) begin
            n_err++;
            $display("FAIL stream_timeout: done never rose, %0d writes seen", got.size());
        end
    endtask

    // Compares the recorded stream against the model and the cycle count.
    task automatic check_stream(input string name);
        int errs = 0;
        n_cmp++;
        if (got.size() != 34) begin
            n_err++;
            $display("FAIL %s_count: got %0d writes want 34", name, got.size());
        end
        for (int i = 0; i < got.size() && i < 34; i++) begin
            n_cmp++;
            if (got[i] !== bswap(exp_value(i))) begin
                n_err++;
                errs++;
                $display("FAIL %s_data[%0d]: got %h want %h", name, i, got[i], bswap(exp_value(i)));
            end
        end
        n_cmp++;
        if (final_cycles !== 16'(67 + stall_cnt)) begin
            n_err++;
            $display("FAIL %s_cycles: got %0d want %0d", name, final_cycles, 67 + stall_cnt);
        end
        $display("stream %s: %0d writes, %0d stalls, cycles %0d, %0d data errors",
                 name, got.size(), stall_cnt, final_cycles, errs);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({mem_wen, mem_addr, mem_wdata, busy, done, cycles} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: wen %b addr %h data %h busy %b done %b cycles %0d want all 0",
                     mem_wen, mem_addr, mem_wdata, busy, done, cycles);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_stream();
        logic [15:0] c0;
        run_stream(0, -1, 0, -1);
        check_stream("plain");
        n_cmp++;
        if (got.size() == 34 && (got[0] !== 32'h68010000 || got[16] !== 32'h62020000 ||
                                 got[33] !== 32'h5DFDFFFF)) begin
            n_err++;
            $display("FAIL plain_markers: got %h %h %h want 68010000 62020000 5dfdffff",
                     got[0], got[16], got[33]);
        end
        n_cmp++;
        if (final_cycles !== 16'd67) begin
            n_err++;
            $display("FAIL plain_cycles67: got %0d want 67", final_cycles);
        end
        c0 = cycles;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_wen !== 1'b0 || cycles !== c0) begin
            n_err++;
            $display("FAIL done_frozen: done %b busy %b wen %b cycles %0d want 1/0/0/%0d",
                     done, busy, mem_wen, cycles, c0);
        end
    endtask

    task automatic test_stall_hold();
        run_stream(0, 11, 5, -1);
        check_stream("stall5");
        n_cmp++;
        if (runs.size() < 12 || runs[11] != 6 || got[11] !== 32'h37000000) begin
            n_err++;
            $display("FAIL stall5_hold: hold %0d data %h want 6 / 37000000",
                     (runs.size() > 11) ? runs[11] : -1, (got.size() > 11) ? got[11] : 32'hX);
        end
        n_cmp++;
        if (final_cycles !== 16'd72) begin
            n_err++;
            $display("FAIL stall5_cycles: got %0d want 72", final_cycles);
        end
    endtask

    task automatic test_start_ignored();
        run_stream(0, -1, 0, 5);
        check_stream("start_ignored");
    endtask

    task automatic test_random_stall();
        for (int r = 0; r < 3; r++) begin
            run_stream(20 + 15 * r, -1, 0, -1);
            check_stream($sformatf("random%0d", r));
        end
    endtask

    task automatic test_mid_reset();
        int  accepted = 0;
        bit  found = 0;
        bit  stray = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 500 && !found; cyc++) begin
            @(negedge clk);
            if (mem_wen === 1'b1) begin
                if (accepted == 20) found = 1;
                else accepted++;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL midreset_reach: only %0d writes before timeout", accepted);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_wen, mem_addr, mem_wdata, busy, done, cycles} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: wen %b addr %h data %h busy %b done %b cycles %0d want all 0",
                     mem_wen, mem_addr, mem_wdata, busy, done, cycles);
        end
        repeat (10) begin
            @(negedge clk);
            if (mem_wen !== 1'b0 || busy !== 1'b0) stray = 1;
        end
        n_cmp++;
        if (stray) begin
            n_err++;
            $display("FAIL midreset_quiet: activity after reset without start");
        end
        run_stream(0, -1, 0, -1);
        check_stream("after_reset");
    endtask

    task automatic test_back_to_back();
        run_stream(0, -1, 0, -1);
        check_stream("restart_a");
        run_stream(0, -1, 0, -1);
        check_stream("restart_b");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_stall_hold();
        test_start_ignored();
        test_random_stall();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
